// File: rtl/ra_builder.sv
// ra_builder: writes the Region Array for the tile grid.
// For each tile (row-major) it writes a control word and then one Object List
// pointer per list type (o, om, t, tm, and pt in v2).
// Ports:
//   clock, reset                   clock and async active-high reset
//   ra_build_start                 start pulse, accepted only when not busy
//   FPU_PARAM_CFG[21]              format select (1 = v2, 6-word entries)
//   REGION_BASE, OL_BASE           region array / object list pool bases
//   TA_ALLOC_CTRL                  per-list OPB size codes
//   tile_xmax, tile_ymax           last tile index (inclusive)
//   cfg_zclear, cfg_flush          control word flags
//   ra_vram_wr/addr/dout/ack       VRAM write port with ack handshake
//   ra_busy, ra_done               status
module ra_builder (
  input  logic        clock,
  input  logic        reset,
  input  logic        ra_build_start,
  input  logic [31:0] FPU_PARAM_CFG,
  input  logic [31:0] REGION_BASE,
  input  logic [31:0] OL_BASE,
  input  logic [31:0] TA_ALLOC_CTRL,
  input  logic [5:0]  tile_xmax,
  input  logic [5:0]  tile_ymax,
  input  logic        cfg_zclear,
  input  logic        cfg_flush,
  output logic        ra_vram_wr,
  output logic [23:0] ra_vram_addr,
  output logic [31:0] ra_vram_dout,
  input  logic        ra_vram_ack,
  output logic        ra_busy,
  output logic        ra_done
);

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 5;
  localparam int unsigned NW = 13;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_nxt;
  logic [2:0]             setup_cnt_q, setup_cnt_nxt;
  logic [2:0]             word_q, word_nxt;
  logic [5:0]             x_q, x_nxt, y_q, y_nxt;
  logic [5:0]             xmax_q, xmax_nxt, ymax_q, ymax_nxt;
  logic [NW-1:0]          n_q, n_nxt;
  logic [AW-1:0]          alloc_q, alloc_nxt;
  logic [AW-1:0]          region_q, region_nxt;
  logic [NL-1:0][AW-1:0]  ptr_q, ptr_nxt;
  logic [NL-1:0][1:0]     sz_q, sz_nxt;
  logic                   v2_q, v2_nxt;
  logic                   zclear_q, zclear_nxt, flush_q, flush_nxt;
  logic                   wr_nxt, busy_nxt, done_nxt;
  logic [AW-1:0]          addr_nxt;
  logic [DW-1:0]          dout_nxt;

  logic [NL-1:0]          list_en;
  logic [NL-1:0][AW-1:0]  stride;
  logic                   tile_last;
  logic [5:0]             nx, ny;
  logic [2:0]             last_word;

  logic unused_inputs;
  assign unused_inputs = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0],
                           REGION_BASE[31:24], OL_BASE[31:24],
                           TA_ALLOC_CTRL[31:18], TA_ALLOC_CTRL[15:14],
                           TA_ALLOC_CTRL[11:10], TA_ALLOC_CTRL[7:6],
                           TA_ALLOC_CTRL[3:2]};

  // Control word: last-tile flag, zclear, flush, tile coordinates.
  function automatic logic [DW-1:0] ctrl_word(input logic last, input logic zc,
                                              input logic fl, input logic [5:0] y,
                                              input logic [5:0] x);
    return {last, zc, 1'b0, fl, 14'd0, y, x, 2'b00};
  endfunction

  // Per-list enable and per-tile pointer stride (1 << (4+s) bytes).
  always_comb begin
    for (int k = 0; k < int'(NL); k++) begin
      list_en[k] = (sz_q[k] != 2'd0) && ((k != int'(NL) - 1) || v2_q);
      stride[k]  = AW'(1) << (3'd4 + {1'b0, sz_q[k]});
    end
  end

  assign last_word = v2_q ? 3'd5 : 3'd4;
  assign tile_last = (x_q == xmax_q) && (y_q == ymax_q);
  assign nx        = (x_q == xmax_q) ? 6'd0 : x_q + 6'd1;
  assign ny        = (x_q == xmax_q) ? y_q + 6'd1 : y_q;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_q;
    setup_cnt_nxt = setup_cnt_q;
    word_nxt      = word_q;
    x_nxt         = x_q;
    y_nxt         = y_q;
    xmax_nxt      = xmax_q;
    ymax_nxt      = ymax_q;
    n_nxt         = n_q;
    alloc_nxt     = alloc_q;
    region_nxt    = region_q;
    ptr_nxt       = ptr_q;
    sz_nxt        = sz_q;
    v2_nxt        = v2_q;
    zclear_nxt    = zclear_q;
    flush_nxt     = flush_q;
    wr_nxt        = ra_vram_wr;
    addr_nxt      = ra_vram_addr;
    dout_nxt      = ra_vram_dout;
    busy_nxt      = ra_busy;
    done_nxt      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (ra_build_start) begin
          state_nxt     = S_SETUP;
          busy_nxt      = 1'b1;
          setup_cnt_nxt = 3'd0;
          xmax_nxt      = tile_xmax;
          ymax_nxt      = tile_ymax;
          // Tile count is a small 7x7 product taken once per build.
          n_nxt         = NW'((NW'(tile_xmax) + NW'(1)) * (NW'(tile_ymax) + NW'(1)));
          alloc_nxt     = OL_BASE[AW-1:0];
          region_nxt    = REGION_BASE[AW-1:0];
          sz_nxt        = {TA_ALLOC_CTRL[17:16], TA_ALLOC_CTRL[13:12],
                           TA_ALLOC_CTRL[9:8], TA_ALLOC_CTRL[5:4],
                           TA_ALLOC_CTRL[1:0]};
          v2_nxt        = FPU_PARAM_CFG[21];
          zclear_nxt    = cfg_zclear;
          flush_nxt     = cfg_flush;
        end
      end

      // One list per cycle: take the current allocation point as that list's
      // base, then advance by N << (4+s) if the list is enabled.
      S_SETUP: begin
        ptr_nxt[setup_cnt_q] = alloc_q;
        if (list_en[setup_cnt_q]) begin
          alloc_nxt = alloc_q + (AW'(n_q) << (3'd4 + {1'b0, sz_q[setup_cnt_q]}));
        end
        if (setup_cnt_q == 3'd4) begin
          state_nxt = S_WRITE;
          wr_nxt    = 1'b1;
          addr_nxt  = region_q;
          dout_nxt  = ctrl_word(n_q == NW'(1), zclear_q, flush_q, 6'd0, 6'd0);
          word_nxt  = 3'd0;
          x_nxt     = 6'd0;
          y_nxt     = 6'd0;
        end else begin
          setup_cnt_nxt = setup_cnt_q + 3'd1;
        end
      end

      // Entries are contiguous, so the address simply steps by one word.
      S_WRITE: begin
        if (ra_vram_wr && ra_vram_ack) begin
          addr_nxt = ra_vram_addr + AW'(4);
          if (word_q == last_word) begin
            for (int k = 0; k < int'(NL); k++) begin
              ptr_nxt[k] = ptr_q[k] + stride[k];
            end
            if (tile_last) begin
              state_nxt = S_DONE;
              wr_nxt    = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              word_nxt = 3'd0;
              x_nxt    = nx;
              y_nxt    = ny;
              dout_nxt = ctrl_word((nx == xmax_q) && (ny == ymax_q),
                                   zclear_q, flush_q, ny, nx);
            end
          end else begin
            // Next word is the pointer for list index word_q.
            word_nxt = word_q + 3'd1;
            dout_nxt = list_en[word_q] ? {8'h00, ptr_q[word_q]} : 32'h8000_0000;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      setup_cnt_q  <= 3'd0;
      word_q       <= 3'd0;
      x_q          <= 6'd0;
      y_q          <= 6'd0;
      xmax_q       <= 6'd0;
      ymax_q       <= 6'd0;
      n_q          <= '0;
      alloc_q      <= '0;
      region_q     <= '0;
      ptr_q        <= '0;
      sz_q         <= '0;
      v2_q         <= 1'b0;
      zclear_q     <= 1'b0;
      flush_q      <= 1'b0;
      ra_vram_wr   <= 1'b0;
      ra_vram_addr <= '0;
      ra_vram_dout <= '0;
      ra_busy      <= 1'b0;
      ra_done      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      setup_cnt_q  <= setup_cnt_nxt;
      word_q       <= word_nxt;
      x_q          <= x_nxt;
      y_q          <= y_nxt;
      xmax_q       <= xmax_nxt;
      ymax_q       <= ymax_nxt;
      n_q          <= n_nxt;
      alloc_q      <= alloc_nxt;
      region_q     <= region_nxt;
      ptr_q        <= ptr_nxt;
      sz_q         <= sz_nxt;
      v2_q         <= v2_nxt;
      zclear_q     <= zclear_nxt;
      flush_q      <= flush_nxt;
      ra_vram_wr   <= wr_nxt;
      ra_vram_addr <= addr_nxt;
      ra_vram_dout <= dout_nxt;
      ra_busy      <= busy_nxt;
      ra_done      <= done_nxt;
    end
  end

endmodule

// File: doc/ra_builder.md
# ra_builder

Region Array builder for the PVR core: the writer side of the Region Array and Object List pointer format consumed by the core's region array parser. On a start pulse it walks the tile grid row-major. For every tile it writes one Region Array entry to VRAM: a control word followed by one Object List pointer per list type. Each pointer addresses that tile's first Object Pointer Block, allocated from OL_BASE according to TA_ALLOC_CTRL.

## Interface
Parameters: none.

Ports:
- clock  in  1  core clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- ra_build_start  in  1  one-cycle start pulse; ignored while ra_busy=1.
- FPU_PARAM_CFG  in  32  bit 21 selects format: 1 = v2 (6-word entries including punch-through); 0 = v1 (5-word entries).
- REGION_BASE  in  32  Region Array byte address; bits [23:0] used.
- OL_BASE  in  32  Object List pool byte address; bits [23:0] used.
- TA_ALLOC_CTRL  in  32  OPB size codes: o [1:0], om [5:4], t [9:8], tm [13:12], pt [17:16].
- tile_xmax, tile_ymax  in  6 each  last tile index, inclusive.
- cfg_zclear, cfg_flush  in  1 each  copied to control word bit 30 and bit 28 respectively.
- ra_vram_wr  out  1  write request.
- ra_vram_addr  out  24  write byte address.
- ra_vram_dout  out  32  write data.
- ra_vram_ack  in  1  write accepted in any cycle where ra_vram_wr=1 and ra_vram_ack=1.
- ra_busy  out  1  build in progress.
- ra_done  out  1  one-cycle completion pulse.

## Operation
- All inputs are latched on an accepted start. Input changes during ra_busy=1 have no effect.
- OPB size code s: 0 = list disabled; 1/2/3 = 8/16/32 words. Per-tile stride bytes_t = 1<<(4+s).
- N = (tile_xmax+1)*(tile_ymax+1), 1..4096.
- List types are always processed in the order o, om, t, tm, pt.
- Base allocation:
  - base_o = OL_BASE.
  - Each following base = previous base + (N << (4+s_prev)).
  - A disabled list adds 0.
  - pt is allocated only in v2.
- States:
  - IDLE.
  - SETUP: 5 cycles, one list type per cycle. Computes bases by shifting; no multiplier.
  - WRITE: word index 0..4 (v1) or 0..5 (v2).
  - DONE.
- Tile loop: y outer, x inner. Tile index i runs from 0 to N-1.
- Entry address = REGION_BASE + i*20 (v1) or i*24 (v2), produced by a running adder.
- Control word:
  - bit 31 = 1 only when i = N-1.
  - bit 30 = cfg_zclear.
  - bit 28 = cfg_flush.
  - [13:8] = y, [7:2] = x.
  - All other bits 0.
- Pointer words:
  - Enabled list: {8'h00, ptr_t}, where ptr_t = base_t + i*bytes_t, kept as a running pointer incremented by bytes_t after each tile.
  - Disabled list: 32'h80000000.
  - In v1, pt is neither written nor allocated.
- All address arithmetic is 24-bit and wraps modulo 2^24 silently.

## Timing
- Reset values: ra_vram_wr=0, ra_vram_addr=0, ra_vram_dout=0, ra_busy=0, ra_done=0, state IDLE.
- A reset asserted mid-build aborts immediately. No partial-entry recovery.
- Cycle numbering from start sampled at cycle 0:
  - ra_busy=1 from cycle 1.
  - SETUP occupies cycles 1–5.
  - ra_vram_wr rises in cycle 6.
- Handshake:
  - addr and dout hold stable while ra_vram_wr=1 and ra_vram_ack=0.
  - After an ack, the next word is presented in the following cycle with ra_vram_wr held at 1.
  - No bubbles, including across entry boundaries.
- Final word: ra_vram_wr deasserts the cycle after its ack. In that same cycle ra_done=1 for exactly one cycle and ra_busy=0.
- With ra_vram_ack tied high, ra_done occurs in cycle 6 + N*W, where W=5 (v1) or 6 (v2).
- A start pulse arriving in the ra_done cycle is accepted.
- A start pulse while ra_busy=1 is dropped.
- ra_vram_ack while ra_vram_wr=0 is ignored.

## Test plan
- **1x1 tile, v1, all sizes 1, REGION_BASE=0x001000, OL_BASE=0x100000, ack high** → writes exactly:
  - 0x1000=0x80000000
  - 0x1004=0x00100000
  - 0x1008=0x00100020
  - 0x100C=0x00100040
  - 0x1010=0x00100060
  - ra_done in cycle 11.
- **2x2 tiles, v2, o=2, om=0, t=1, tm=0, pt=3, OL_BASE=0x200000, REGION_BASE=0** → 24 writes. Tile 3 at 0x48:
  - 0x80000104
  - 0x002000C0
  - 0x80000000
  - 0x00200160
  - 0x80000000
  - 0x00200300
  - Tiles 0–2 have bit 31 clear.
- **Same as the 2x2 case, ack driven pseudo-randomly at 30%** → identical write sequence. addr/dout stable during stalls; no write lost or duplicated.
- **cfg_zclear=1, cfg_flush=1, tile_xmax=2, tile_ymax=0** → control words:
  - 0x50000000
  - 0x50000004
  - 0xD0000008
- **Start pulse at cycle 20 mid-build** → ignored. Write count and final data unchanged.
- **reset asserted during the 3rd word of tile 1** → same cycle: ra_vram_wr=0, ra_busy=0. A new start then rebuilds from tile 0 correctly.
